// File: rtl/core_run_monitor.sv
// Run monitor for the RISC-V core: counts run cycles and branch-prediction outcomes, applies a watchdog,
// snapshots the register file at run end and streams it out. Optional counters: CORE_RUN_MONITOR_PRED_EN.
`timescale 1ns/1ps
module core_run_monitor #(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int NREGS     = 32,
  parameter int DUMP_REGS = 16,
  parameter int TIMEOUT   = 9000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  completed,
  input  logic [XLEN-1:0]       pc,
  input  logic                  pred_valid,
  input  logic                  pred_hit,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycles,
  output logic [CNT_W-1:0]      pred_total,
  output logic [CNT_W-1:0]      pred_succ,
  output logic [CNT_W-1:0]      pred_fail,
  output logic [XLEN-1:0]       pc_final,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [4:0]            dump_idx,
  output logic [XLEN-1:0]       dump_data,
  output logic                  dump_last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [4:0]       LAST_IDX = 5'(DUMP_REGS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   pc_final_q, pc_final_d;
  logic [XLEN-1:0]   snap_q [DUMP_REGS];
  logic [XLEN-1:0]   snap_d [DUMP_REGS];
  logic [4:0]        dump_idx_q, dump_idx_d;
  logic [XLEN-1:0]   dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;
  logic              dump_valid_q, dump_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              run_start_s;
  logic              capture_s;
  logic              xfer_s;
  logic [XLEN-1:0]   rd_data_s;
  logic              regs_unused_s;

  // Registers beyond the dumped range are never captured.
  assign regs_unused_s = ^regs_flat;

  // Run-control FSM next state, run counter and end-of-run capture.
  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    dump_idx_d  = dump_idx_q;
    snap_d      = snap_q;
    pc_final_d  = pc_final_q;
    run_start_s = 1'b0;
    capture_s   = 1'b0;
    xfer_s      = dump_valid_q & dump_ready;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          run_start_s = 1'b1;
          state_d     = S_RUN;
          cycles_d    = {CNT_W{1'b0}};
          timeout_d   = 1'b0;
          dump_idx_d  = 5'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        cycles_d = sat_inc(cycles_q);
        // Completion takes priority over a watchdog expiring on the same cycle.
        if (completed) begin
          capture_s = 1'b1;
          timeout_d = 1'b0;
          state_d   = S_DUMP;
        end else if (cycles_d == TMO) begin
          capture_s = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DUMP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DUMP: begin
        if (xfer_s) begin
          if (dump_last_q) begin
            state_d = S_DONE;
          end else begin
            dump_idx_d = dump_idx_q + 5'd1;
          end
        end else begin
          state_d = S_DUMP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (capture_s) begin
      pc_final_d = pc;
      for (int r = 0; r < DUMP_REGS; r++) begin
        snap_d[r] = regs_flat[r*XLEN +: XLEN];
      end
    end else begin
      pc_final_d = pc_final_q;
    end
  end

  // Output staging: every visible output is computed from next-state values and registered.
  always_comb begin
    rd_data_s = {XLEN{1'b0}};
    for (int r = 0; r < DUMP_REGS; r++) begin
      rd_data_s = rd_data_s | ((dump_idx_d == 5'(r)) ? snap_d[r] : {XLEN{1'b0}});
    end
    busy_d       = (state_d == S_RUN) || (state_d == S_DUMP);
    done_d       = (state_d == S_DONE);
    dump_valid_d = (state_d == S_DUMP);
    dump_last_d  = dump_valid_d && (dump_idx_d == LAST_IDX);
    dump_data_d  = dump_valid_d ? rd_data_s : dump_data_q;
  end

  // Main state and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cycles_q     <= {CNT_W{1'b0}};
      timeout_q    <= 1'b0;
      pc_final_q   <= {XLEN{1'b0}};
      snap_q       <= '{default: {XLEN{1'b0}}};
      dump_idx_q   <= 5'd0;
      dump_data_q  <= {XLEN{1'b0}};
      dump_last_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      timeout_q    <= timeout_d;
      pc_final_q   <= pc_final_d;
      snap_q       <= snap_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      dump_valid_q <= dump_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycles     = cycles_q;
  assign pc_final   = pc_final_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;

`ifdef CORE_RUN_MONITOR_PRED_EN
  logic [CNT_W-1:0] pred_total_q, pred_total_d;
  logic [CNT_W-1:0] pred_succ_q, pred_succ_d;
  logic [CNT_W-1:0] pred_fail_q, pred_fail_d;

  // Prediction outcome counters; an event on the capture cycle still counts.
  always_comb begin
    pred_total_d = pred_total_q;
    pred_succ_d  = pred_succ_q;
    pred_fail_d  = pred_fail_q;
    if (run_start_s) begin
      pred_total_d = {CNT_W{1'b0}};
      pred_succ_d  = {CNT_W{1'b0}};
      pred_fail_d  = {CNT_W{1'b0}};
    end else if ((state_q == S_RUN) && pred_valid) begin
      pred_total_d = sat_inc(pred_total_q);
      if (pred_hit) begin
        pred_succ_d = sat_inc(pred_succ_q);
      end else begin
        pred_fail_d = sat_inc(pred_fail_q);
      end
    end else begin
      pred_total_d = pred_total_q;
    end
  end

  // Prediction counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_total_q <= {CNT_W{1'b0}};
      pred_succ_q  <= {CNT_W{1'b0}};
      pred_fail_q  <= {CNT_W{1'b0}};
    end else begin
      pred_total_q <= pred_total_d;
      pred_succ_q  <= pred_succ_d;
      pred_fail_q  <= pred_fail_d;
    end
  end

  assign pred_total = pred_total_q;
  assign pred_succ  = pred_succ_q;
  assign pred_fail  = pred_fail_q;
`else
  logic pred_unused_s;

  assign pred_unused_s = pred_valid ^ pred_hit ^ run_start_s;
  assign pred_total    = {CNT_W{1'b0}};
  assign pred_succ     = {CNT_W{1'b0}};
  assign pred_fail     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: three instances (default, TIMEOUT=50, CNT_W=4/TIMEOUT=15) driven by a
// scenario table plus random runs, checked against a run-level reference model.
`timescale 1ns/1ps
module tb_core_run_monitor;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int DR    = 16;
`ifdef CORE_RUN_MONITOR_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstn;
  logic                  start_v [3];
  logic                  completed_v [3];
  logic [XLEN-1:0]       pc;
  logic                  pred_valid, pred_hit, dump_ready;
  logic [XLEN-1:0]       regs_arr [NREGS];
  logic [NREGS*XLEN-1:0] regs_flat;

  always_comb begin
    regs_flat = '0;
    for (int r = 0; r < NREGS; r++) regs_flat[r*XLEN +: XLEN] = regs_arr[r];
  end

  logic b0, d0, t0, v0, l0, b1, d1, t1, v1, l1, b2, d2, t2, v2, l2;
  logic [31:0] c0, pt0, ps0, pf0, pc0, dd0, c1, pt1, ps1, pf1, pc1, dd1, pc2, dd2;
  logic [3:0]  c2, pt2, ps2, pf2;
  logic [4:0]  i0, i1, i2;

  core_run_monitor u_dut0 (
    .clk(clk), .rstn(rstn), .start(start_v[0]), .completed(completed_v[0]), .pc(pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .regs_flat(regs_flat),
    .busy(b0), .done(d0), .timeout(t0), .cycles(c0), .pred_total(pt0), .pred_succ(ps0),
    .pred_fail(pf0), .pc_final(pc0), .dump_valid(v0), .dump_ready(dump_ready),
    .dump_idx(i0), .dump_data(dd0), .dump_last(l0));

  core_run_monitor #(.TIMEOUT(50)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start_v[1]), .completed(completed_v[1]), .pc(pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .regs_flat(regs_flat),
    .busy(b1), .done(d1), .timeout(t1), .cycles(c1), .pred_total(pt1), .pred_succ(ps1),
    .pred_fail(pf1), .pc_final(pc1), .dump_valid(v1), .dump_ready(dump_ready),
    .dump_idx(i1), .dump_data(dd1), .dump_last(l1));

  core_run_monitor #(.CNT_W(4), .TIMEOUT(15)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start_v[2]), .completed(completed_v[2]), .pc(pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .regs_flat(regs_flat),
    .busy(b2), .done(d2), .timeout(t2), .cycles(c2), .pred_total(pt2), .pred_succ(ps2),
    .pred_fail(pf2), .pc_final(pc2), .dump_valid(v2), .dump_ready(dump_ready),
    .dump_idx(i2), .dump_data(dd2), .dump_last(l2));

  int sel;
  logic o_busy, o_done, o_tmo, o_dv, o_last;
  logic [31:0] o_cyc, o_pt, o_ps, o_pf, o_pc, o_dd;
  logic [4:0]  o_idx;

  always_comb begin
    case (sel)
      0: begin
        o_busy = b0; o_done = d0; o_tmo = t0; o_dv = v0; o_last = l0; o_cyc = c0;
        o_pt = pt0; o_ps = ps0; o_pf = pf0; o_pc = pc0; o_dd = dd0; o_idx = i0;
      end
      1: begin
        o_busy = b1; o_done = d1; o_tmo = t1; o_dv = v1; o_last = l1; o_cyc = c1;
        o_pt = pt1; o_ps = ps1; o_pf = pf1; o_pc = pc1; o_dd = dd1; o_idx = i1;
      end
      default: begin
        o_busy = b2; o_done = d2; o_tmo = t2; o_dv = v2; o_last = l2; o_cyc = {28'd0, c2};
        o_pt = {28'd0, pt2}; o_ps = {28'd0, ps2}; o_pf = {28'd0, pf2}; o_pc = pc2; o_dd = dd2; o_idx = i2;
      end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d @%0t): got 0x%08h, expected 0x%08h", name, sel, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] satv(input int n, input longint maxc);
    return (longint'(n) > maxc) ? 32'(maxc) : 32'(n);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_timeout"}, 32'(o_tmo), 32'd0);
    chk({tag, "_cycles"}, o_cyc, 32'd0);
    chk({tag, "_pred_total"}, o_pt, 32'd0);
    chk({tag, "_pred_succ"}, o_ps, 32'd0);
    chk({tag, "_pred_fail"}, o_pf, 32'd0);
    chk({tag, "_pc_final"}, o_pc, 32'd0);
    chk({tag, "_dump_valid"}, 32'(o_dv), 32'd0);
    chk({tag, "_dump_idx"}, 32'(o_idx), 32'd0);
    chk({tag, "_dump_data"}, o_dd, 32'd0);
    chk({tag, "_dump_last"}, 32'(o_last), 32'd0);
  endtask

  // Runs one complete start..done sequence on instance s; must be entered at a falling edge.
  // cmp_at: RUN cycle carrying completed (0 = never). pmode: 0 random(pct), 1 = 20 events/13 hits ending
  // on the completion cycle, 2 = event every cycle. exp_cyc < 0 lets the model supply cycles/timeout.
  task automatic do_run(input int s, input int cmp_at, input int pmode, input int pct, input int rdy,
                        input bit fixed, input int rst_idx, input int exp_cyc, input bit exp_tmo);
    int tmo, k_end, n_tot, n_succ, n_fail, idx, cyc;
    longint maxc;
    bit ev, hit, fin, e_tmo;
    logic [31:0] exp_pc, e_cyc;
    logic [31:0] snap [DR];
    tmo   = (s == 0) ? 9000 : (s == 1) ? 50 : 15;
    maxc  = (s == 2) ? 64'd15 : 64'hFFFF_FFFF;
    sel   = s;
    k_end = (cmp_at >= 1 && cmp_at <= tmo) ? cmp_at : tmo;
    n_tot = 0; n_succ = 0; n_fail = 0; exp_pc = '0;
    e_cyc = (exp_cyc < 0) ? 32'(k_end) : 32'(exp_cyc);
    e_tmo = (exp_cyc < 0) ? (cmp_at != k_end) : exp_tmo;
    if (fixed) begin
      for (int r = 0; r < NREGS; r++) regs_arr[r] = 32'(r * 17);
      regs_arr[1] = 32'd5;
      regs_arr[2] = 32'hFFFF_FFFD;
    end
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_cycles_clear", o_cyc, 32'd0);
    chk("start_pred_clear", o_pt, 32'd0);
    chk("start_timeout_clear", 32'(o_tmo), 32'd0);
    for (int k = 1; k <= k_end; k++) begin
      completed_v[s] = (k == cmp_at);
      pc = fixed ? 32'h0000_0140 : $urandom;
      if (!fixed) for (int r = 0; r < NREGS; r++) regs_arr[r] = $urandom;
      case (pmode)
        1: begin ev = (k > k_end - 20); hit = (k - (k_end - 20)) <= 13; end
        2: begin ev = 1'b1; hit = k[0]; end
        default: begin ev = ($urandom_range(99) < pct); hit = $urandom_range(1) == 1; end
      endcase
      pred_valid = ev;
      pred_hit   = ev ? hit : ($urandom_range(1) == 1);
      if (ev) begin
        n_tot++;
        if (hit) n_succ++; else n_fail++;
      end
      if (k == k_end) begin
        exp_pc = pc;
        for (int r = 0; r < DR; r++) snap[r] = regs_arr[r];
      end
      @(negedge clk);
    end
    completed_v[s] = 1'b0;
    pred_valid = 1'b0;
    chk("end_cycles", o_cyc, e_cyc);
    chk("end_timeout", 32'(o_tmo), 32'(e_tmo));
    chk("end_pc_final", o_pc, exp_pc);
    chk("end_pred_total", o_pt, PRED_EN ? satv(n_tot, maxc) : 32'd0);
    chk("end_pred_succ", o_ps, PRED_EN ? satv(n_succ, maxc) : 32'd0);
    chk("end_pred_fail", o_pf, PRED_EN ? satv(n_fail, maxc) : 32'd0);
    if (pmode == 1) begin
      chk("pattern_total", o_pt, PRED_EN ? 32'd20 : 32'd0);
      chk("pattern_succ", o_ps, PRED_EN ? 32'd13 : 32'd0);
      chk("pattern_fail", o_pf, PRED_EN ? 32'd7 : 32'd0);
    end
    chk("dump_entry_busy", 32'(o_busy), 32'd1);
    // Register file moves on after capture; the stream must still carry the snapshot.
    for (int r = 0; r < NREGS; r++) regs_arr[r] = $urandom;
    idx = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 2000) begin
      if (idx == rst_idx) begin
        #2 rstn = 1'b0;
        #1 chk_all_zero("async_reset");
        dump_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      dump_ready = ($urandom_range(99) < rdy);
      start_v[s] = ($urandom_range(7) == 0);
      chk("dump_valid", 32'(o_dv), 32'd1);
      chk("dump_idx", 32'(o_idx), 32'(idx));
      chk("dump_data", o_dd, snap[idx]);
      chk("dump_last", 32'(o_last), 32'(idx == DR - 1));
      cyc++;
      @(negedge clk);
      start_v[s] = 1'b0;
      if (dump_ready) begin
        if (idx == DR - 1) fin = 1'b1;
        else idx++;
      end
    end
    dump_ready = 1'b0;
    if (!fin) chk("dump_bound_expired", 32'd0, 32'd1);
    if (rdy == 100) chk("dump_rate", 32'(cyc), 32'(DR));
    chk("done_flag", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd0);
    chk("done_dump_valid", 32'(o_dv), 32'd0);
    completed_v[s] = 1'b1;
    @(negedge clk);
    completed_v[s] = 1'b0;
    chk("done_hold_flag", 32'(o_done), 32'd1);
    chk("done_hold_cycles", o_cyc, e_cyc);
    chk("done_hold_timeout", 32'(o_tmo), 32'(e_tmo));
    chk("done_hold_pc", o_pc, exp_pc);
    chk("done_hold_pred", o_pt, PRED_EN ? satv(n_tot, maxc) : 32'd0);
  endtask

  typedef struct {
    int sel; int cmp_at; int pmode; int pct; int rdy; bit fixed; int rst_idx; int exp_cyc; bit exp_tmo;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: bench did not finish, got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int s, c;
    tbl[0] = '{0, 100, 0, 30, 100, 1'b1, -1, 100, 1'b0};
    tbl[1] = '{1,   0, 0, 50, 100, 1'b0, -1,  50, 1'b1};
    tbl[2] = '{1,  50, 0, 50, 100, 1'b0, -1,  50, 1'b0};
    tbl[3] = '{0,  30, 1,  0, 100, 1'b0, -1,  30, 1'b0};
    tbl[4] = '{0,  40, 0, 60,  30, 1'b0, -1,  40, 1'b0};
    tbl[5] = '{2,   0, 2,  0, 100, 1'b0, -1,  15, 1'b1};
    tbl[6] = '{2,   7, 0, 70,  50, 1'b0, -1,   7, 1'b0};
    tbl[7] = '{0,  20, 0, 40, 100, 1'b0,  7,  20, 1'b0};
    tbl[8] = '{0,   1, 0, 90, 100, 1'b0, -1,   1, 1'b0};
    tbl[9] = '{2,  15, 0, 50,  70, 1'b0, -1,  15, 1'b0};

    rstn = 1'b0; pc = '0; pred_valid = 1'b0; pred_hit = 1'b0; dump_ready = 1'b0; sel = 0;
    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; completed_v[i] = 1'b0; end
    for (int r = 0; r < NREGS; r++) regs_arr[r] = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1 chk_all_zero("reset");
    end
    @(negedge clk);
    rstn = 1'b1;

    for (int t = 0; t < 10; t++) begin
      do_run(tbl[t].sel, tbl[t].cmp_at, tbl[t].pmode, tbl[t].pct, tbl[t].rdy,
             tbl[t].fixed, tbl[t].rst_idx, tbl[t].exp_cyc, tbl[t].exp_tmo);
    end

    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(2);
      if (s == 0) c = $urandom_range(250, 1);
      else c = $urandom_range((s == 1) ? 55 : 20);
      do_run(s, c, 0, $urandom_range(100), $urandom_range(100, 20), 1'b0, -1, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
